// File: rtl/seg7_scan_driver_if.sv
// Bus between a BCD value source and the multiplexed seven-segment scan driver.
// The master side supplies the digits and display options; the slave side drives the panel.
interface seg7_scan_driver_if;
   logic [31:0] bcd_in;
   logic        load;
   logic        lz_blank;
   logic [7:0]  blink_mask;
   logic [7:0]  dp_mask;
   logic [7:0]  AN;
   logic [7:0]  SEG;
   logic        frame_done;

   modport master (
      output bcd_in, load, lz_blank, blink_mask, dp_mask,
      input  AN, SEG, frame_done
   );

   modport slave (
      input  bcd_in, load, lz_blank, blink_mask, dp_mask,
      output AN, SEG, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scanner with frame-synchronous double buffering,
// leading-zero blanking, per-digit blink and decimal points, and an anti-ghosting guard.
module seg7_scan_driver #(
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 4,
   parameter int BLINK_FRAMES = 128
) (
   input logic              clk,
   input logic              rst,
   seg7_scan_driver_if.slave bus
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] GUARD_CNT  = DW'(GUARD);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   typedef struct packed {
      logic [DW-1:0] div_cnt;
      logic [2:0]    digit_idx;
      logic [FW-1:0] frame_cnt;
      logic          blink_phase;
      logic [31:0]   active;
      logic [31:0]   pending;
      logic          pend_flag;
   } scan_state_t;

   scan_state_t state_q, state_d;
   logic        terminal, boundary;
   logic [7:0]  an_d, seg_d, an_q, seg_q;
   logic        frame_done_q;
   logic [7:0]  zero_from;
   logic [3:0]  cur_nibble;
   logic        cur_dark;

   // Active-low glyphs for g..a; invalid BCD renders as a dash.
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'h40;
         4'd1:    g = 7'h79;
         4'd2:    g = 7'h24;
         4'd3:    g = 7'h30;
         4'd4:    g = 7'h19;
         4'd5:    g = 7'h12;
         4'd6:    g = 7'h02;
         4'd7:    g = 7'h78;
         4'd8:    g = 7'h00;
         4'd9:    g = 7'h10;
         default: g = 7'h3F;
      endcase
      return g;
   endfunction

   assign terminal = (state_q.div_cnt == DIV_LAST);
   assign boundary = terminal && (state_q.digit_idx == 3'd7);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= '0;
         an_q         <= 8'hFF;
         seg_q        <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register samples the pre-edge values.
         state_q      <= state_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= boundary;
      end
   end

   // Next-state logic: divider, digit index, buffers and blink timebase.
   always_comb begin
      // NOTE: start from the held value so no path leaves state_d unassigned (no latch).
      state_d = state_q;

      if (terminal) begin
         state_d.div_cnt   = '0;
         state_d.digit_idx = state_q.digit_idx + 3'd1;
      end else begin
         state_d.div_cnt   = state_q.div_cnt + 1'b1;
      end

      if (bus.load) begin
         state_d.pending   = bus.bcd_in;
         state_d.pend_flag = 1'b1;
      end

      // A load in the boundary cycle itself wins over anything already pending.
      if (boundary) begin
         if (bus.load)
            state_d.active = bus.bcd_in;
         else if (state_q.pend_flag)
            state_d.active = state_q.pending;
         state_d.pend_flag = 1'b0;

         if (state_q.frame_cnt == FRAME_LAST) begin
            state_d.frame_cnt   = '0;
            state_d.blink_phase = ~state_q.blink_phase;
         end else begin
            state_d.frame_cnt   = state_q.frame_cnt + 1'b1;
         end
      end
   end

   // zero_from[i] is set when digits i..7 of the active value are all zero.
   always_comb begin
      logic run;
      run       = 1'b1;
      zero_from = '0;
      for (int i = 7; i >= 0; i--) begin
         run          = run && (state_q.active[4*i +: 4] == 4'd0);
         zero_from[i] = run;
      end
   end

   // Output logic for the slot selected by the current divider/index state.
   always_comb begin
      cur_nibble = state_q.active[{state_q.digit_idx, 2'b00} +: 4];
      cur_dark   = (bus.lz_blank && (state_q.digit_idx != 3'd0) && zero_from[state_q.digit_idx])
                || (state_q.blink_phase && bus.blink_mask[state_q.digit_idx]);
      an_d       = 8'hFF;
      seg_d      = 8'hFF;
      if (!(state_q.div_cnt < GUARD_CNT) && !cur_dark) begin
         an_d  = ~(8'b1 << state_q.digit_idx);
         seg_d = {~bus.dp_mask[state_q.digit_idx], glyph(cur_nibble)};
      end
   end

   assign bus.AN         = an_q;
   assign bus.SEG        = seg_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-cycle slot, 1-cycle guard and 2-frame blink.
// Each frame is sampled on every falling edge and compared against hand-computed digit tables.
module tb_seg7_scan_driver;
   localparam int SCAN_DIV     = 4;
   localparam int GUARD        = 1;
   localparam int BLINK_FRAMES = 2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .SCAN_DIV    (SCAN_DIV),
      .GUARD       (GUARD),
      .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // seg holds digit7..digit0 SEG bytes (digit d at [8d+:8]); lit marks digits with an anode on.
   typedef struct {
      logic [31:0] bcd;
      logic        lz;
      logic [7:0]  dp;
      logic [63:0] seg;
      logic [7:0]  lit;
   } vec_t;

   vec_t vecs [8];

   localparam logic [63:0] SEG_ZERO = 64'hFFFFFFFF_FFFFFFC0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Called on a falling edge; returns on the next falling edge with load low again.
   task automatic pulse_load(input logic [31:0] v);
      bus.bcd_in = v;
      bus.load   = 1'b1;
      @(negedge clk);
      bus.load   = 1'b0;
   endtask

   task automatic wait_fd();
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         seen = bus.frame_done;
         n++;
      end
      check("frame_done wait", 32'(seen), 32'd1);
   endtask

   // Samples one full frame; must start on the falling edge where frame_done is seen
   // (or right after reset release) and ends on the next such edge.
   task automatic capture(input string tag, input logic [63:0] seg, input logic [7:0] lit,
                          input int load_k, input logic [31:0] load_val);
      int d;
      int s;
      logic [7:0] exp_an;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         d = (k - 1) / 4;
         s = (k - 1) % 4;
         exp_an = lit[d] ? ~(8'b1 << d) : 8'hFF;
         if (s == 0)
            check($sformatf("%s guard d%0d", tag, d), {16'h0, bus.AN, bus.SEG}, 32'h0000FFFF);
         else
            check($sformatf("%s d%0d s%0d", tag, d, s), {16'h0, bus.AN, bus.SEG},
                  {16'h0, exp_an, seg[8*d +: 8]});
         if (k == 1)
            check($sformatf("%s frame_done low", tag), 32'(bus.frame_done), 32'd0);
         if (k == 32)
            check($sformatf("%s frame_done pulse", tag), 32'(bus.frame_done), 32'd1);
         if (k == load_k) begin
            bus.bcd_in = load_val;
            bus.load   = 1'b1;
         end
         if (k == load_k + 1)
            bus.load = 1'b0;
      end
   endtask

   initial begin
      int n;

      vecs[0] = '{32'h12345678, 1'b1, 8'h00, 64'hF9A4B099_9282F880, 8'hFF};
      vecs[1] = '{32'h0000000A, 1'b0, 8'h00, 64'hC0C0C0C0_C0C0C0BF, 8'hFF};
      vecs[2] = '{32'h00000007, 1'b0, 8'h02, 64'hC0C0C0C0_C0C040F8, 8'hFF};
      vecs[3] = '{32'h90000000, 1'b1, 8'h81, 64'h10C0C0C0_C0C0C040, 8'hFF};
      vecs[4] = '{32'h0F0E0000, 1'b1, 8'h00, 64'hFFBFC0BF_C0C0C0C0, 8'h7F};
      vecs[5] = '{32'h00012345, 1'b1, 8'hFF, 64'hFFFFFF79_24301912, 8'h1F};
      vecs[6] = '{32'h00000000, 1'b1, 8'h00, SEG_ZERO,              8'h01};
      vecs[7] = '{32'h00000000, 1'b1, 8'h03, 64'hFFFFFFFF_FFFFFF40, 8'h01};

      rst            = 1'b1;
      bus.bcd_in     = '0;
      bus.load       = 1'b0;
      bus.lz_blank   = 1'b1;
      bus.blink_mask = 8'h00;
      bus.dp_mask    = 8'h00;
      repeat (3) @(negedge clk);
      check("reset AN", 32'(bus.AN), 32'hFF);
      check("reset SEG", 32'(bus.SEG), 32'hFF);
      check("reset frame_done", 32'(bus.frame_done), 32'd0);
      rst = 1'b0;
      capture("post-reset", SEG_ZERO, 8'h01, -1, '0);

      // Asynchronous reset in the middle of a lit slot, with a load still pending.
      pulse_load(32'h12345678);
      n = 0;
      while (bus.AN == 8'hFF && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("lit before reset AN", 32'(bus.AN), 32'hFE);
      check("lit before reset SEG", 32'(bus.SEG), 32'hC0);
      #2 rst = 1'b1;
      #1;
      check("async reset AN", 32'(bus.AN), 32'hFF);
      check("async reset SEG", 32'(bus.SEG), 32'hFF);
      check("async reset frame_done", 32'(bus.frame_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      capture("after reset f0", SEG_ZERO, 8'h01, -1, '0);
      capture("after reset f1", SEG_ZERO, 8'h01, -1, '0);

      // Mid-frame load is held back until the boundary.
      capture("before swap", SEG_ZERO, 8'h01, 5, 32'h00002048);
      capture("2048", 64'hFFFFFFFF_A4C09980, 8'h0F, -1, '0);

      // Load in the boundary cycle itself goes straight to the active buffer.
      capture("boundary load frame", 64'hFFFFFFFF_A4C09980, 8'h0F, 31, 32'h00000099);
      capture("boundary load", 64'hFFFFFFFF_FFFF9090, 8'h03, -1, '0);

      foreach (vecs[i]) begin
         bus.lz_blank = vecs[i].lz;
         bus.dp_mask  = vecs[i].dp;
         pulse_load(vecs[i].bcd);
         wait_fd();
         capture($sformatf("vec%0d", i), vecs[i].seg, vecs[i].lit, -1, '0);
      end

      // Two loads in one frame: only the newer value may ever be displayed.
      bus.lz_blank = 1'b1;
      bus.dp_mask  = 8'h00;
      repeat (10) @(negedge clk);
      pulse_load(32'h12345678);
      @(negedge clk);
      pulse_load(32'h87654321);
      wait_fd();
      capture("newest wins", 64'h80F88292_99B0A4F9, 8'hFF, -1, '0);

      // Blink on digit 0 from a known phase: two frames lit, two dark, then lit again.
      rst            = 1'b1;
      bus.lz_blank   = 1'b0;
      bus.dp_mask    = 8'h02;
      bus.blink_mask = 8'h01;
      @(negedge clk);
      rst = 1'b0;
      capture("blink f0", 64'hC0C0C0C0_C0C040C0, 8'hFF, 5, 32'h00000007);
      capture("blink f1", 64'hC0C0C0C0_C0C040F8, 8'hFF, -1, '0);
      capture("blink f2", 64'hC0C0C0C0_C0C040FF, 8'hFE, -1, '0);
      capture("blink f3", 64'hC0C0C0C0_C0C040FF, 8'hFE, -1, '0);
      capture("blink f4", 64'hC0C0C0C0_C0C040F8, 8'hFF, -1, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1);
   end

endmodule
